// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared widths, response codes and FSM state types
package axi_lite_pkg;

  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic {
    WR_IDLE,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

endpackage

// File: rtl/axi_lite_if.sv
// rtl/axi_lite_if.sv - AXI4-Lite channel bundle with master and slave views
interface axi_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_lite_regfile.sv
// rtl/axi_lite_regfile.sv - register array with byte-enable write and async read
module axi_lite_regfile #(
  parameter int NUM_REGS   = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        we_i,
  input  logic [$clog2(NUM_REGS)-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]       wdata_i,
  input  logic [DATA_WIDTH/8-1:0]     wstrb_i,
  input  logic [$clog2(NUM_REGS)-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0]       rdata_o
);

  localparam int STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb_i[b]) begin
          mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi_lite_slave.sv
// rtl/axi_lite_slave.sv - AXI4-Lite slave over a word-addressed register file
module axi_lite_slave
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int NUM_REGS   = 32
) (
  input  logic      aclk,
  input  logic      areset_n,
  axi_lite_if.slave s_axi_lite
);

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int STRB_W = DATA_WIDTH / 8;

  wr_state_t             wr_state_q, wr_state_d;
  logic                  aw_cap_q, aw_cap_d;
  logic                  w_cap_q, w_cap_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  resp_t                 bresp_q, bresp_d;
  rd_state_t             rd_state_q, rd_state_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  resp_t                 rresp_q, rresp_d;

  logic                  awready, wready, arready, rf_we;
  logic                  aw_in_range, ar_in_range;
  logic [DATA_WIDTH-1:0] rf_rdata;
  logic                  unused_addr_bits;

  // Anything above the index field selects a nonexistent register.
  assign aw_in_range = (awaddr_q >> (IDX_W + 2)) == '0;
  assign ar_in_range = (s_axi_lite.araddr >> (IDX_W + 2)) == '0;
  assign unused_addr_bits = ^{awaddr_q[1:0], s_axi_lite.araddr[1:0]};

  axi_lite_regfile #(
    .NUM_REGS  (NUM_REGS),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_regfile (
    .clk_i  (aclk),
    .rst_ni (areset_n),
    .we_i   (rf_we),
    .waddr_i(awaddr_q[IDX_W+1:2]),
    .wdata_i(wdata_q),
    .wstrb_i(wstrb_q),
    .raddr_i(s_axi_lite.araddr[IDX_W+1:2]),
    .rdata_o(rf_rdata)
  );

  always_comb begin
    wr_state_d = wr_state_q;
    aw_cap_d   = aw_cap_q;
    w_cap_d    = w_cap_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    awready    = 1'b0;
    wready     = 1'b0;
    rf_we      = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        awready = !aw_cap_q;
        wready  = !w_cap_q;
        if (aw_cap_q && w_cap_q) begin
          rf_we      = aw_in_range;
          bresp_d    = aw_in_range ? OKAY : SLVERR;
          bvalid_d   = 1'b1;
          aw_cap_d   = 1'b0;
          w_cap_d    = 1'b0;
          wr_state_d = WR_RESP;
        end else begin
          if (s_axi_lite.awvalid && awready) begin
            aw_cap_d = 1'b1;
            awaddr_d = s_axi_lite.awaddr;
          end
          if (s_axi_lite.wvalid && wready) begin
            w_cap_d = 1'b1;
            wdata_d = s_axi_lite.wdata;
            wstrb_d = s_axi_lite.wstrb;
          end
        end
      end
      WR_RESP: begin
        if (s_axi_lite.bready) begin
          bvalid_d   = 1'b0;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // Read data is sampled from the array before any same-edge write lands.
  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    arready    = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        arready = 1'b1;
        if (s_axi_lite.arvalid) begin
          rdata_d    = ar_in_range ? rf_rdata : '0;
          rresp_d    = ar_in_range ? OKAY : SLVERR;
          rvalid_d   = 1'b1;
          rd_state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (s_axi_lite.rready) begin
          rvalid_d   = 1'b0;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wr_state_q <= WR_IDLE;
      aw_cap_q   <= 1'b0;
      w_cap_q    <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= OKAY;
      rd_state_q <= RD_IDLE;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      aw_cap_q   <= aw_cap_d;
      w_cap_q    <= w_cap_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rd_state_q <= rd_state_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign s_axi_lite.awready = awready;
  assign s_axi_lite.wready  = wready;
  assign s_axi_lite.bvalid  = bvalid_q;
  assign s_axi_lite.bresp   = bresp_q;
  assign s_axi_lite.arready = arready;
  assign s_axi_lite.rvalid  = rvalid_q;
  assign s_axi_lite.rdata   = rdata_q;
  assign s_axi_lite.rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_slave.sv
// tb/tb_axi_lite_slave.sv - randomized scoreboard bench for axi_lite_slave
module tb_axi_lite_slave;

  localparam int NUM_REGS = 32;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = $clog2(NUM_REGS);

  logic aclk = 1'b0;
  logic areset_n = 1'b0;
  always #5 aclk = ~aclk;

  axi_lite_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_lite_slave #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NUM_REGS  (NUM_REGS)
  ) dut (
    .aclk      (aclk),
    .areset_n  (areset_n),
    .s_axi_lite(bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          b_count  = 0;
  logic [31:0] model [NUM_REGS];
  logic [1:0]  exp_b_q [$];
  logic [33:0] exp_r_q [$];
  logic [33:0] mon_r;
  logic [1:0]  mon_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic in_range(input logic [31:0] a);
    return a < 32'(NUM_REGS * 4);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
  endtask

  // Monitor: samples just after the falling edge, where the values equal those at the next rising edge.
  initial begin
    forever begin
      @(negedge aclk);
      #1;
      if (areset_n) begin
        if (bus.bvalid && bus.bready) begin
          if (exp_b_q.size() == 0) begin
            check("b_unexpected", {31'd0, bus.bvalid}, 32'd0);
          end else begin
            mon_b = exp_b_q.pop_front();
            check("bresp", {30'd0, bus.bresp}, {30'd0, mon_b});
          end
          b_count++;
        end
        if (bus.rvalid && bus.rready) begin
          if (exp_r_q.size() == 0) begin
            check("r_unexpected", {31'd0, bus.rvalid}, 32'd0);
          end else begin
            mon_r = exp_r_q.pop_front();
            check("rdata", bus.rdata, mon_r[31:0]);
            check("rresp", {30'd0, bus.rresp}, {30'd0, mon_r[33:32]});
          end
        end
      end
    end
  end

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    logic [1:0] exp;
    int start;
    int c;
    exp = in_range(addr) ? 2'b00 : 2'b10;
    exp_b_q.push_back(exp);
    start = b_count;
    fork
      begin
        int ca;
        repeat (aw_dly) @(negedge aclk);
        bus.awaddr = addr;
        bus.awvalid = 1'b1;
        ca = 0;
        while (!bus.awready && ca < 50) begin @(negedge aclk); ca++; end
        check("awready_wait", {31'd0, bus.awready}, 32'd1);
        @(negedge aclk);
        bus.awvalid = 1'b0;
      end
      begin
        int cw;
        repeat (w_dly) @(negedge aclk);
        bus.wdata = data;
        bus.wstrb = strb;
        bus.wvalid = 1'b1;
        cw = 0;
        while (!bus.wready && cw < 50) begin @(negedge aclk); cw++; end
        check("wready_wait", {31'd0, bus.wready}, 32'd1);
        @(negedge aclk);
        bus.wvalid = 1'b0;
      end
    join
    c = 0;
    while (!bus.bvalid && c < 50) begin @(negedge aclk); c++; end
    check("bvalid_wait", {31'd0, bus.bvalid}, 32'd1);
    check("b_latency", 32'(c), 32'd1);
    repeat (b_dly) begin
      check("bvalid_hold", {31'd0, bus.bvalid}, 32'd1);
      check("bresp_hold", {30'd0, bus.bresp}, {30'd0, exp});
      @(negedge aclk);
    end
    bus.bready = 1'b1;
    @(negedge aclk);
    bus.bready = 1'b0;
    check("b_once", 32'(b_count - start), 32'd1);
    check("bvalid_low", {31'd0, bus.bvalid}, 32'd0);
    if (in_range(addr)) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model[addr[IW+1:2]][8*b +: 8] = data[8*b +: 8];
      end
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly);
    logic [33:0] exp;
    int c;
    repeat (ar_dly) @(negedge aclk);
    bus.araddr = addr;
    bus.arvalid = 1'b1;
    c = 0;
    while (!bus.arready && c < 50) begin @(negedge aclk); c++; end
    check("arready_wait", {31'd0, bus.arready}, 32'd1);
    exp = in_range(addr) ? {2'b00, model[addr[IW+1:2]]} : {2'b10, 32'h0};
    exp_r_q.push_back(exp);
    @(negedge aclk);
    bus.arvalid = 1'b0;
    check("rvalid_latency", {31'd0, bus.rvalid}, 32'd1);
    repeat (r_dly) begin
      check("rvalid_hold", {31'd0, bus.rvalid}, 32'd1);
      check("rdata_hold", bus.rdata, exp[31:0]);
      @(negedge aclk);
    end
    bus.rready = 1'b1;
    @(negedge aclk);
    bus.rready = 1'b0;
    check("rvalid_low", {31'd0, bus.rvalid}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    clear_model();

    areset_n = 1'b0;
    repeat (2) @(negedge aclk);
    check("rst_bvalid", {31'd0, bus.bvalid}, 32'd0);
    check("rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
    areset_n = 1'b1;
    @(negedge aclk);
    check("rst_arready", {31'd0, bus.arready}, 32'd1);
    check("rst_awready", {31'd0, bus.awready}, 32'd1);
    check("rst_wready", {31'd0, bus.wready}, 32'd1);
    do_read(32'h08, 0, 0);

    do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_read(32'h04, 0, 0);

    // Reset lands between the handshake edge and the commit edge.
    bus.awaddr = 32'h0C; bus.awvalid = 1'b1;
    bus.wdata = 32'h0BADF00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge aclk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    areset_n = 1'b0;
    clear_model();
    repeat (2) @(negedge aclk);
    areset_n = 1'b1;
    @(negedge aclk);
    check("abort_bvalid", {31'd0, bus.bvalid}, 32'd0);
    check("abort_awready", {31'd0, bus.awready}, 32'd1);
    check("abort_wready", {31'd0, bus.wready}, 32'd1);
    do_read(32'h0C, 0, 0);
    do_read(32'h04, 0, 0);

    do_write(32'h10, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    do_write(32'h10, 32'h12345678, 4'b0011, 0, 0, 0);
    do_read(32'h10, 0, 0);
    check("strobe_model", model[4], 32'hFFFF5678);

    do_write(32'h20, 32'h11112222, 4'hF, 0, 3, 5);
    do_write(32'h24, 32'h33334444, 4'hF, 3, 0, 5);
    do_read(32'h20, 0, 0);
    do_read(32'h24, 0, 0);

    do_write(32'h80, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    do_read(32'h80, 0, 0);

    fork
      do_write(32'h00, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
      begin
        @(negedge aclk);
        do_read(32'h00, 0, 3);
      end
    join
    do_read(32'h00, 0, 0);

    for (int i = 0; i < 60; i++) begin
      a = 32'($urandom_range(0, 35) * 4) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a[20] = 1'b1;
      d = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 2));
      end else begin
        do_read(a, $urandom_range(0, 2), $urandom_range(0, 2));
      end
    end

    for (int i = 0; i < NUM_REGS; i++) do_read(32'(i * 4), 0, 0);

    repeat (3) @(negedge aclk);
    check("b_queue_empty", 32'(exp_b_q.size()), 32'd0);
    check("r_queue_empty", 32'(exp_r_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
